// File: rtl/reg_write_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared types and sizing helpers for the register write arbiter.
// Revision : 1.0
// ============================================================================
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arb_if
// Brief    : Requester/register bus of the write arbiter; the lock vector
//            exists only when REG_ARB_LOCK_EN is defined.
// Revision : 1.0
// ============================================================================
interface reg_write_arb_if
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  reg_load;
    logic [WIDTH-1:0]      reg_data;
    logic                  busy;

    modport master (
        output req,
        output req_data,
`ifdef REG_ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  ack,
        input  reg_load,
        input  reg_data,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
`ifdef REG_ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output ack,
        output reg_load,
        output reg_data,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin search: first set req bit at or above
//            ptr, wrapping at NREQ.
// Revision : 1.0
// ============================================================================
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = ptr_w(DEF_NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    // Scan from the farthest offset down so the nearest hit overwrites.
    always_comb begin : p_search
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                winner = PTR_W'(idx);
            end
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/reg_write_arb.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arb
// Brief    : Round-robin write-port arbiter for a shared register. Optional
//            grant hold for back-to-back writes via REG_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
module reg_write_arb
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_write_arb_if.slave bus
);

    localparam int              PTR_W  = ptr_w(NREQ);
    localparam logic [NREQ-1:0] c_one  = NREQ'(1);
    localparam logic [PTR_W-1:0] c_last = PTR_W'(NREQ - 1);

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_reg_load;
    logic [WIDTH-1:0]  r_reg_data;
    logic              r_busy;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_winner;

    logic [PTR_W-1:0]  w_pick_idx;
    logic              w_pick_valid;
    logic [WIDTH-1:0]  w_pick_data;
    logic [WIDTH-1:0]  w_hold_data;
    logic              w_lock_hold;
    logic [PTR_W-1:0]  w_next_ptr;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_pick_idx),
        .valid  (w_pick_valid)
    );

    assign w_pick_data = bus.req_data[int'(w_pick_idx) * WIDTH +: WIDTH];
    assign w_next_ptr  = (r_winner == c_last) ? '0 : r_winner + 1'b1;

`ifdef REG_ARB_LOCK_EN
    assign w_lock_hold = bus.lock[r_winner] & bus.req[r_winner];
    assign w_hold_data = bus.req_data[int'(r_winner) * WIDTH +: WIDTH];
`else
    assign w_lock_hold = 1'b0;
    assign w_hold_data = r_reg_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_reg_load <= 1'b0;
            r_reg_data <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= '0;
            r_winner   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack      <= '0;
                    if (w_pick_valid) begin
                        r_state    <= LOAD;
                        r_winner   <= w_pick_idx;
                        r_gnt      <= c_one << w_pick_idx;
                        r_reg_data <= w_pick_data;
                        r_reg_load <= 1'b1;
                        r_busy     <= 1'b1;
                    end else begin
                        r_gnt      <= '0;
                        r_reg_load <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state    <= DONE;
                    r_reg_load <= 1'b0;
                    r_ack      <= r_gnt;
                end
                DONE: begin
                    r_ack <= '0;
                    // A locked winner reloads without giving up the grant or the pointer.
                    if (w_lock_hold) begin
                        r_state    <= LOAD;
                        r_reg_data <= w_hold_data;
                        r_reg_load <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_gnt      <= '0;
                    r_ack      <= '0;
                    r_reg_load <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.ack      = r_ack;
    assign bus.reg_load = r_reg_load;
    assign bus.reg_data = r_reg_data;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arb
// Brief    : Directed self-checking bench for reg_write_arb (NREQ=4, WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_reg_write_arb;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   viol;
    logic prev_load;
    logic [3:0] reg_q;

    reg_write_arb_if #(.NREQ(4), .WIDTH(4)) bus ();

    reg_write_arb #(.NREQ(4), .WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the shared register being written.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            reg_q <= 4'h0;
        else if (bus.reg_load) reg_q <= bus.reg_data;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(bus.gnt) > 1 || $countones(bus.ack) > 1) viol++;
            if (bus.ack != 4'b0 && bus.ack != bus.gnt) viol++;
            if (bus.reg_load && prev_load) viol++;
        end
        prev_load = bus.reg_load;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        int k;
        k = 0;
        while (bus.gnt == 4'b0 && k < 12) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, (k < 12) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic expect_grant(input string tag, input int w, input logic [3:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        wait_grant(tag);
        check({tag, "_gnt"},  bus.gnt, oh);
        check({tag, "_load"}, bus.reg_load, 1);
        check({tag, "_data"}, bus.reg_data, d);
        check({tag, "_busy"}, bus.busy, 1);
        tick();
        check({tag, "_ack"},   bus.ack, oh);
        check({tag, "_load2"}, bus.reg_load, 0);
        check({tag, "_gnth"},  bus.gnt, oh);
        check({tag, "_reg"},   reg_q, d);
        bus.req[w] = 1'b0;
        tick();
        check({tag, "_ackclr"}, bus.ack, 0);
        check({tag, "_gntclr"}, bus.gnt, 0);
        check({tag, "_idle"},   bus.busy, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        viol      = 0;
        prev_load = 1'b0;
        rst_n        = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = 16'h4321;
`ifdef REG_ARB_LOCK_EN
        bus.lock     = 4'b0000;
`endif
        tick();
        tick();
        check("rst_gnt",  bus.gnt, 0);
        check("rst_ack",  bus.ack, 0);
        check("rst_load", bus.reg_load, 0);
        check("rst_data", bus.reg_data, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;

        // Fairness from reset: 0,1,2,3 then pointer wraps back to 0.
        expect_grant("rr0", 0, 4'h1);
        expect_grant("rr1", 1, 4'h2);
        expect_grant("rr2", 2, 4'h3);
        expect_grant("rr3", 3, 4'h4);
        bus.req      = 4'b0001;
        bus.req_data = 16'h0009;
        expect_grant("wrap", 0, 4'h9);

        bus.req      = 4'b0100;
        bus.req_data = 16'h0A00;
        expect_grant("single", 2, 4'hA);
        check("single_hold", bus.reg_data, 4'hA);

        // Withdrawal during LOAD; late data change must be ignored.
        bus.req      = 4'b0010;
        bus.req_data = 16'h0070;
        wait_grant("wd");
        check("wd_gnt",  bus.gnt, 4'b0010);
        check("wd_data", bus.reg_data, 4'h7);
        bus.req      = 4'b0000;
        bus.req_data = 16'h00F0;
        tick();
        check("wd_ack", bus.ack, 4'b0010);
        check("wd_reg", reg_q, 4'h7);
        tick();
        check("wd_ackclr", bus.ack, 0);
        tick();
        check("wd_once", bus.ack, 0);
        check("wd_busy", bus.busy, 0);
        check("wd_regd", bus.reg_data, 4'h7);

        // Reset during LOAD abandons the write.
        bus.req      = 4'b1000;
        bus.req_data = 16'hC000;
        wait_grant("mr");
        check("mr_gnt", bus.gnt, 4'b1000);
        rst_n = 1'b0;
        #1;
        check("mr_gnt0",  bus.gnt, 0);
        check("mr_load0", bus.reg_load, 0);
        check("mr_data0", bus.reg_data, 0);
        check("mr_busy0", bus.busy, 0);
        bus.req = 4'b0000;
        tick();
        check("mr_noack", bus.ack, 0);
        rst_n        = 1'b1;
        bus.req      = 4'b1111;
        bus.req_data = 16'h8765;
        expect_grant("ptr0", 0, 4'h5);
        bus.req = 4'b0000;
        tick();
        tick();

`ifdef REG_ARB_LOCK_EN
        // Locked requester 1 writes twice, 2 cycles apart, while 0 waits.
        bus.req      = 4'b0011;
        bus.lock     = 4'b0010;
        bus.req_data = 16'h0030;
        wait_grant("lk");
        check("lk_gnt",  bus.gnt, 4'b0010);
        check("lk_data", bus.reg_data, 4'h3);
        tick();
        check("lk_ack1", bus.ack, 4'b0010);
        check("lk_reg1", reg_q, 4'h3);
        bus.req_data = 16'h0050;
        tick();
        check("lk_gnt2",  bus.gnt, 4'b0010);
        check("lk_load2", bus.reg_load, 1);
        check("lk_data2", bus.reg_data, 4'h5);
        check("lk_ack0",  bus.ack, 0);
        bus.lock = 4'b0000;
        tick();
        check("lk_ack2", bus.ack, 4'b0010);
        check("lk_reg2", reg_q, 4'h5);
        bus.req[1] = 1'b0;
        tick();
        check("lk_rel", bus.gnt, 0);
        expect_grant("lk_next", 0, 4'h0);
`endif

        check("onehot_viol", viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
